branch_resolve_queue: RTL and testbench

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

---
 rtl/branch_resolve_queue.sv | 102 ++++++++++
 tb/tb_branch_resolve_queue.sv | 118 +++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: FIFO of predicted conditional branches resolved in order by EX,
// producing predictor feedback, mispredict redirect/flush and performance counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int AW = `ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_dec_valid,
  input  logic [AW-1:0]            i_dec_pc,
  input  logic                     i_dec_prediction,
  input  logic [AW-1:0]            i_dec_recovery_target,
  output logic                     o_dec_ready,
  input  logic                     i_ex_valid,
  input  logic                     i_ex_outcome,
  output logic                     o_fb_valid,
  output logic [AW-1:0]            o_fb_pc,
  output logic                     o_fb_prediction,
  output logic                     o_fb_outcome,
  output logic                     o_redirect_valid,
  output logic [AW-1:0]            o_redirect_target,
  output logic                     o_flush,
  output logic [$clog2(DEPTH):0]   o_occupancy,
  output logic [31:0]              o_branch_count,
  output logic [31:0]              o_mispredict_count,
  output logic                     o_error
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0] pc_q [DEPTH];
  logic [AW-1:0] rec_q [DEPTH];
  logic [DEPTH-1:0] pred_q;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;
  logic fb_valid_q, fb_pred_q, fb_out_q, redir_q, err_q;
  logic [AW-1:0] fb_pc_q, target_q;
  logic push, pop, mis;
  assign o_dec_ready = cnt_q != CW'(DEPTH);
  assign push = i_dec_valid && o_dec_ready;
  assign pop = i_ex_valid && cnt_q != '0;
  assign mis = pop && (i_ex_outcome != pred_q[rp_q]);
  // a mispredict empties the queue and drops any same-cycle wrong-path push
  always_comb begin
    wp_d = mis ? '0 : wp_q + PW'(push);
    rp_d = mis ? '0 : rp_q + PW'(pop);
    cnt_d = mis ? '0 : cnt_q + CW'(push) - CW'(pop);
    bcnt_d = (pop && ~&bcnt_q) ? bcnt_q + 32'd1 : bcnt_q;
    mcnt_d = (mis && ~&mcnt_q) ? mcnt_q + 32'd1 : mcnt_q;
  end
  always_ff @(posedge clk)
    if (push && !mis) begin
      pc_q[wp_q] <= i_dec_pc;
      rec_q[wp_q] <= i_dec_recovery_target;
      pred_q[wp_q] <= i_dec_prediction;
    end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      bcnt_q <= '0;
      mcnt_q <= '0;
      fb_valid_q <= 1'b0;
      fb_pc_q <= '0;
      fb_pred_q <= 1'b0;
      fb_out_q <= 1'b0;
      redir_q <= 1'b0;
      target_q <= '0;
      err_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
      fb_valid_q <= pop;
      redir_q <= mis;
      err_q <= err_q | (i_ex_valid && cnt_q == '0);
      if (pop) begin
        fb_pc_q <= pc_q[rp_q];
        fb_pred_q <= pred_q[rp_q];
        fb_out_q <= i_ex_outcome;
      end
      if (mis) target_q <= rec_q[rp_q];
    end
  end
  assign o_fb_valid = fb_valid_q;
  assign o_fb_pc = fb_pc_q;
  assign o_fb_prediction = fb_pred_q;
  assign o_fb_outcome = fb_out_q;
  assign o_redirect_valid = redir_q;
  assign o_flush = redir_q;
  assign o_redirect_target = target_q;
  assign o_occupancy = cnt_q;
  assign o_branch_count = bcnt_q;
  assign o_mispredict_count = mcnt_q;
  assign o_error = err_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed vectors with hand-computed expectations for branch_resolve_queue.
module tb_branch_resolve_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dv = 1'b0, dpred = 1'b0, ev = 1'b0, eo = 1'b0;
  logic [31:0] dpc = '0, drec = '0;
  logic rdy, fbv, fbp, fbo, rv, fl, err;
  logic [31:0] fbpc, tgt, bc, mc;
  logic [2:0] occ;
  int vec = 0;
  int errs = 0;
  always #5 clk = ~clk;
  branch_resolve_queue #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_dec_valid(dv), .i_dec_pc(dpc), .i_dec_prediction(dpred), .i_dec_recovery_target(drec),
    .o_dec_ready(rdy), .i_ex_valid(ev), .i_ex_outcome(eo),
    .o_fb_valid(fbv), .o_fb_pc(fbpc), .o_fb_prediction(fbp), .o_fb_outcome(fbo),
    .o_redirect_valid(rv), .o_redirect_target(tgt), .o_flush(fl),
    .o_occupancy(occ), .o_branch_count(bc), .o_mispredict_count(mc), .o_error(err)
  );
  task automatic cyc(input logic v, input logic [31:0] pc, input logic p, input logic e, input logic o);
    dv = v; dpc = pc; dpred = p; drec = pc + 32'h8; ev = e; eo = o;
    @(negedge clk);
    dv = 1'b0; ev = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_occ", 32'(occ), 0); chk("rst_rdy", 32'(rdy), 1); chk("rst_fbv", 32'(fbv), 0);
    chk("rst_rv", 32'(rv), 0); chk("rst_fl", 32'(fl), 0); chk("rst_err", 32'(err), 0);
    chk("rst_bc", bc, 0); chk("rst_mc", mc, 0); chk("rst_fbpc", fbpc, 0);
    chk("rst_tgt", tgt, 0); chk("rst_fbp", 32'(fbp), 0); chk("rst_fbo", 32'(fbo), 0);
    rst_n = 1'b1;
    cyc(1, 32'h100, 1, 0, 0); cyc(1, 32'h200, 1, 0, 0); cyc(1, 32'h300, 1, 0, 0);
    chk("in_order_occ", 32'(occ), 3);
    cyc(0, 0, 0, 1, 1);
    chk("pop1_fbv", 32'(fbv), 1); chk("pop1_pc", fbpc, 32'h100); chk("pop1_out", 32'(fbo), 1);
    chk("pop1_pred", 32'(fbp), 1); chk("pop1_rv", 32'(rv), 0);
    cyc(0, 0, 0, 0, 0);
    chk("idle_fbv", 32'(fbv), 0); chk("idle_hold_pc", fbpc, 32'h100);
    cyc(0, 0, 0, 1, 1); chk("pop2_pc", fbpc, 32'h200);
    cyc(0, 0, 0, 1, 1); chk("pop3_pc", fbpc, 32'h300); chk("pop3_rv", 32'(rv), 0);
    chk("seq_occ", 32'(occ), 0); chk("seq_bc", bc, 3); chk("seq_mc", mc, 0);
    cyc(1, 32'h10, 1, 0, 0); cyc(1, 32'h20, 1, 0, 0); cyc(1, 32'h30, 1, 0, 0); cyc(1, 32'h40, 1, 0, 0);
    chk("full_rdy", 32'(rdy), 0); chk("full_occ", 32'(occ), 4);
    cyc(1, 32'h50, 1, 0, 0);
    chk("full_push_occ", 32'(occ), 4);
    cyc(1, 32'h60, 1, 1, 1);
    chk("full_pp_occ", 32'(occ), 3); chk("full_pp_pc", fbpc, 32'h10); chk("full_pp_rdy", 32'(rdy), 1);
    cyc(0, 0, 0, 1, 1); chk("drain1_pc", fbpc, 32'h20);
    cyc(0, 0, 0, 1, 1); chk("drain2_pc", fbpc, 32'h30);
    cyc(0, 0, 0, 1, 1); chk("drain3_pc", fbpc, 32'h40);
    chk("drain_occ", 32'(occ), 0); chk("drain_bc", bc, 7);
    cyc(1, 32'h100, 1, 0, 0); cyc(1, 32'h200, 1, 0, 0); cyc(1, 32'h300, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("mis_rv", 32'(rv), 1); chk("mis_fl", 32'(fl), 1); chk("mis_tgt", tgt, 32'h108);
    chk("mis_occ", 32'(occ), 0); chk("mis_mc", mc, 1); chk("mis_bc", bc, 8);
    chk("mis_fbv", 32'(fbv), 1); chk("mis_fbo", 32'(fbo), 0); chk("mis_fbp", 32'(fbp), 1);
    cyc(0, 0, 0, 0, 0);
    chk("mis_rv_pulse", 32'(rv), 0); chk("mis_fl_pulse", 32'(fl), 0); chk("mis_rdy", 32'(rdy), 1);
    cyc(1, 32'h400, 0, 0, 0);
    cyc(1, 32'h500, 1, 1, 1);
    chk("mispush_occ", 32'(occ), 0); chk("mispush_tgt", tgt, 32'h408);
    chk("mispush_mc", mc, 2); chk("mispush_bc", bc, 9);
    cyc(1, 32'h600, 1, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("after_mis_pc", fbpc, 32'h600); chk("after_mis_rv", 32'(rv), 0);
    cyc(1, 32'h700, 1, 0, 0);
    cyc(1, 32'h800, 1, 1, 1);
    chk("pp_occ", 32'(occ), 1); chk("pp_pc", fbpc, 32'h700);
    cyc(0, 0, 0, 1, 1);
    chk("pp2_pc", fbpc, 32'h800); chk("pp_bc", bc, 12); chk("pp_end_occ", 32'(occ), 0);
    chk("pre_err", 32'(err), 0);
    cyc(0, 0, 0, 1, 0);
    chk("empty_err", 32'(err), 1); chk("empty_fbv", 32'(fbv), 0); chk("empty_rv", 32'(rv), 0);
    chk("empty_bc", bc, 12); chk("empty_mc", mc, 2); chk("empty_occ", 32'(occ), 0);
    cyc(0, 0, 0, 0, 0);
    chk("err_sticky", 32'(err), 1);
    cyc(1, 32'h900, 1, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("err_sticky2", 32'(err), 1); chk("err_pc", fbpc, 32'h900); chk("err_bc", bc, 13);
    force dut.bcnt_q = 32'hFFFF_FFFE;
    #1 release dut.bcnt_q;
    cyc(1, 32'hA00, 1, 0, 0);
    cyc(1, 32'hB00, 1, 1, 1);
    chk("sat_bc1", bc, 32'hFFFF_FFFF);
    cyc(0, 0, 0, 1, 1);
    chk("sat_bc2", bc, 32'hFFFF_FFFF); chk("sat_pc", fbpc, 32'hB00);
    force dut.mcnt_q = 32'hFFFF_FFFF;
    #1 release dut.mcnt_q;
    cyc(1, 32'hC00, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("sat_mc", mc, 32'hFFFF_FFFF); chk("sat_mc_rv", 32'(rv), 1);
    cyc(1, 32'hD00, 0, 0, 0); cyc(1, 32'hE00, 0, 0, 0);
    chk("pre_rst_occ", 32'(occ), 2);
    rst_n = 1'b0;
    cyc(0, 0, 0, 1, 1);
    chk("mrst_occ", 32'(occ), 0); chk("mrst_rdy", 32'(rdy), 1); chk("mrst_fbv", 32'(fbv), 0);
    chk("mrst_rv", 32'(rv), 0); chk("mrst_fl", 32'(fl), 0); chk("mrst_err", 32'(err), 0);
    chk("mrst_bc", bc, 0); chk("mrst_mc", mc, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    chk("post_rst_fbv", 32'(fbv), 0); chk("post_rst_rv", 32'(rv), 0); chk("post_rst_occ", 32'(occ), 0);
    cyc(1, 32'hF00, 1, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("post_rst_pc", fbpc, 32'hF00); chk("post_rst_bc", bc, 1); chk("post_rst_err", 32'(err), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
